// File: rtl/tickgen_baud.sv
// tickgen_baud: programmable UART oversample/bit/mid-bit tick generator with burst mode.
// Define TICKGEN_FRAC_EN to add the fractional divisor input i_frac and its accumulator.
module tickgen_baud #(
  parameter int CNT_W   = 16,
  parameter int OVS     = 16,
  parameter int DIV_RST = 651,
  parameter int NBIT_W  = 4,
  parameter int FRAC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  i_div,
  input  logic              i_div_load,
`ifdef TICKGEN_FRAC_EN
  input  logic [FRAC_W-1:0] i_frac,
`endif
  input  logic              i_oneshot,
  input  logic              i_start,
  input  logic [NBIT_W-1:0] i_nbits,
  output logic              o_tick_ovs,
  output logic              o_tick_bit,
  output logic              o_tick_mid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_err
);
  localparam int OVS_W = $clog2(OVS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, r_div_act, r_div_shadow;
  logic [OVS_W-1:0]  r_ovs;
  logic [NBIT_W-1:0] r_bitcnt, r_nb;
  logic              r_pend, r_tick_ovs, r_tick_bit, r_tick_mid, r_done, r_err;
  logic              w_adv, w_wrap, w_bit, w_mid, w_extra, w_start, w_last_bit, w_div_ok, w_apply;
  logic [CNT_W:0]    w_last;
  // Free-run advances only while parked in IDLE; burst mode advances only in RUN.
  assign w_adv      = enable & (r_state == RUN | (r_state == IDLE & ~i_oneshot));
  assign w_last     = {1'b0, r_div_act} - {{CNT_W{1'b0}}, 1'b1} + {{CNT_W{1'b0}}, w_extra};
  assign w_wrap     = w_adv & ({1'b0, r_cnt} == w_last);
  assign w_bit      = w_wrap & (r_ovs == OVS_W'(OVS - 1));
  assign w_mid      = w_wrap & (r_ovs == OVS_W'(OVS / 2 - 1));
  assign w_last_bit = r_bitcnt == r_nb - 1'b1;
  assign w_div_ok   = i_div >= CNT_W'(2);
  assign w_apply    = r_pend & (~w_adv | w_wrap);
  assign o_tick_ovs = r_tick_ovs;
  assign o_tick_bit = r_tick_bit;
  assign o_tick_mid = r_tick_mid;
  assign o_busy     = r_state == RUN;
  assign o_done     = r_done;
  assign o_div_err  = r_err;
  always_comb begin
    w_state_nxt = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: if (enable & i_oneshot & i_start) begin
        w_state_nxt = RUN;
        w_start = 1'b1;
      end
      RUN:  if (w_bit & w_last_bit) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ovs        <= '0;
      r_bitcnt     <= '0;
      r_nb         <= '0;
      r_div_act    <= CNT_W'(DIV_RST);
      r_div_shadow <= CNT_W'(DIV_RST);
      r_pend       <= 1'b0;
      r_tick_ovs   <= 1'b0;
      r_tick_bit   <= 1'b0;
      r_tick_mid   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ovs      <= '0;
      r_bitcnt   <= '0;
      r_pend     <= 1'b0;
      r_tick_ovs <= 1'b0;
      r_tick_bit <= 1'b0;
      r_tick_mid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (r_pend) r_div_act <= r_div_shadow;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_ovs <= w_wrap;
      r_tick_bit <= w_bit;
      r_tick_mid <= w_mid;
      r_done     <= r_state == DONE;
      if (w_start | r_state == DONE) begin
        r_cnt    <= '0;
        r_ovs    <= '0;
        r_bitcnt <= '0;
      end else if (w_adv) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        if (w_wrap) r_ovs <= r_ovs + 1'b1;
        if (w_bit) r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_start) r_nb <= (i_nbits == '0) ? NBIT_W'(1) : i_nbits;
      if (w_apply) begin
        r_div_act <= r_div_shadow;
        r_pend    <= 1'b0;
      end
      // A load overrides the apply above, so a load on a wrap waits for the next wrap.
      if (i_div_load & w_div_ok) begin
        r_div_shadow <= i_div;
        r_pend       <= 1'b1;
      end
      if (i_div_load & ~w_div_ok) r_err <= 1'b1;
    end
`ifdef TICKGEN_FRAC_EN
  logic [FRAC_W-1:0] r_acc, r_frac_act, r_frac_shadow;
  logic              r_extra;
  logic [FRAC_W:0]   w_acc_sum;
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_act};
  assign w_extra   = r_extra;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc         <= '0;
      r_frac_act    <= '0;
      r_frac_shadow <= '0;
      r_extra       <= 1'b0;
    end else if (clear) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
      if (r_pend) r_frac_act <= r_frac_shadow;
    end else begin
      if (w_wrap) {r_extra, r_acc} <= w_acc_sum;
      if (w_apply) r_frac_act <= r_frac_shadow;
      if (i_div_load & w_div_ok) r_frac_shadow <= i_frac;
    end
`else
  assign w_extra = 1'b0;
`endif
endmodule

// File: tb/tb_tickgen_baud.sv
// tb_tickgen_baud: directed checks of free-run timing, divisor reload, burst mode and reset.
module tb_tickgen_baud;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [15:0] i_div = '0;
  logic        i_div_load = 1'b0, i_oneshot = 1'b0, i_start = 1'b0;
  logic [3:0]  i_nbits = '0;
`ifdef TICKGEN_FRAC_EN
  logic [3:0]  i_frac = '0;
`endif
  logic a_ovs, a_bit, a_mid, a_busy, a_done, a_err;
  logic b_ovs, b_bit, b_mid, b_busy, b_done, b_err;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int t0, t1, t2, t3, t4, t5, s;

  tickgen_baud u_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .i_div(i_div), .i_div_load(i_div_load),
`ifdef TICKGEN_FRAC_EN
    .i_frac(i_frac),
`endif
    .i_oneshot(i_oneshot), .i_start(i_start), .i_nbits(i_nbits),
    .o_tick_ovs(a_ovs), .o_tick_bit(a_bit), .o_tick_mid(a_mid),
    .o_busy(a_busy), .o_done(a_done), .o_div_err(a_err)
  );
  tickgen_baud #(.OVS(4)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .i_div(i_div), .i_div_load(i_div_load),
`ifdef TICKGEN_FRAC_EN
    .i_frac(i_frac),
`endif
    .i_oneshot(i_oneshot), .i_start(i_start), .i_nbits(i_nbits),
    .o_tick_ovs(b_ovs), .o_tick_bit(b_bit), .o_tick_mid(b_mid),
    .o_busy(b_busy), .o_done(b_done), .o_div_err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sel: 0 a_ovs, 1 a_bit, 2 a_mid, 3 b_bit, 4 b_done; at = -1 when the budget expires
  task automatic wait_tick(input int sel, input int budget, output int at);
    logic hit;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      hit = sel == 0 ? a_ovs : sel == 1 ? a_bit : sel == 2 ? a_mid : sel == 3 ? b_bit : b_done;
      if (hit) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic load(input int d);
    i_div = 16'(d);
    i_div_load = 1'b1;
    @(negedge clk);
    i_div_load = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ovs", a_ovs, 0);
    chk("rst_bit", a_bit, 0);
    chk("rst_mid", a_mid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    enable = 1'b1;
    wait_tick(0, 700, t0);
    wait_tick(0, 700, t1);
    chk("ovs_period", t1 - t0, 651);
    wait_tick(1, 11000, t2);
    chk("bit_with_ovs", a_ovs, 1);
    wait_tick(2, 11000, t3);
    chk("mid_after_bit", t3 - t2, 5208);
    wait_tick(1, 11000, t4);
    chk("bit_period", t4 - t2, 10416);
    repeat (300) @(negedge clk);
    load(10);
    wait_tick(0, 700, t0);
    chk("load_cur_period", t0 - t4, 651);
    wait_tick(0, 700, t1);
    chk("load_new_period1", t1 - t0, 10);
    wait_tick(0, 700, t2);
    chk("load_new_period2", t2 - t1, 10);
    repeat (9) @(negedge clk);
    load(20);
    chk("wrap_tick_at_load", a_ovs, 1);
    t3 = cyc;
    wait_tick(0, 100, t4);
    chk("wrap_load_old", t4 - t3, 10);
    wait_tick(0, 100, t5);
    chk("wrap_load_new", t5 - t4, 20);
    load(1);
    chk("err_set", a_err, 1);
    wait_tick(0, 100, t0);
    wait_tick(0, 100, t1);
    chk("err_div_kept", t1 - t0, 20);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("err_cleared", a_err, 0);
    i_oneshot = 1'b1;
    load(4);
    @(negedge clk);
    chk("idle_busy", b_busy, 0);
    i_nbits = 4'd3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    s = cyc;
    chk("run_busy", b_busy, 1);
    wait_tick(3, 40, t0);
    chk("burst_bit1", t0 - s, 16);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_tick(3, 40, t1);
    chk("burst_bit2", t1 - t0, 16);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    wait_tick(3, 60, t2);
    chk("burst_bit3_frozen", t2 - t1, 36);
    wait_tick(4, 10, t3);
    chk("done_delay", t3 - t2, 1);
    chk("done_busy", b_busy, 0);
    wait_tick(3, 40, t4);
    chk("no_extra_bit", t4, -1);
    i_nbits = 4'd0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    s = cyc;
    wait_tick(3, 40, t0);
    chk("nb0_bit", t0 - s, 16);
    wait_tick(4, 40, t1);
    chk("nb0_done", t1 - t0, 1);
    i_nbits = 4'd3;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_tick(3, 40, t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_done", b_done, 0);
    chk("rst_b_ovs", b_ovs, 0);
    chk("rst_b_bit", b_bit, 0);
    rst = 1'b0;
    i_oneshot = 1'b0;
    wait_tick(0, 700, t0);
    wait_tick(0, 700, t1);
    chk("rst_div_act", t1 - t0, 651);
`ifdef TICKGEN_FRAC_EN
    i_frac = 4'd4;
    load(10);
    wait_tick(0, 700, t0);
    wait_tick(0, 100, t1);
    for (int k = 0; k < 16; k++) wait_tick(0, 100, t2);
    chk("frac_16_periods", t2 - t1, 164);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
